// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lsu
// Description : Load/store unit between a CPU request/response channel and a
//               single-port 32-bit data memory with combinational read.
//               Byte, halfword and word accesses, little-endian byte lanes,
//               sign/zero extension of loads, and read-modify-write for
//               sub-word stores (ACCESS reads the old word, WRITE stores the
//               merged word).
// Options     : DMEM_LSU_MISALIGN_TRAP_EN - when defined, misaligned halfword
//               and word accesses return resp_err=1 without touching memory;
//               when undefined, the low address bits are ignored.
// Ports       : clock, reset_n        - clock, async active-low reset
//               req_*                 - CPU request channel (valid/ready)
//               resp_*                - response channel (valid/ready)
//               mem_we/addr/wd/rd     - data memory port (word addressed)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
    parameter int DMEM_AW = 9
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [DMEM_AW+1:0] req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic               mem_we,
    output logic [DMEM_AW-1:0] mem_addr,
    output logic [31:0]        mem_wd,
    input  logic [31:0]        mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Registered request fields
    logic               op_we;
    logic [1:0]         op_size;
    logic               op_uns;
    logic [DMEM_AW+1:0] op_addr;
    logic [31:0]        op_wdata;

    // Merged word for sub-word stores, captured in ACCESS
    logic [31:0]        merge_word;
    logic [31:0]        rdata_q;
    logic               err_q;

    logic               is_word;
    logic               is_half;
    logic               misalign;
    logic [4:0]         byte_sh;
    logic [4:0]         half_sh;
    logic [31:0]        byte_shifted;
    logic [7:0]         byte_val;
    logic [15:0]        half_val;
    logic [31:0]        load_val;
    logic [31:0]        lane_mask;
    logic [31:0]        lane_data;
    logic [31:0]        merged;

    // Reserved size 11 behaves as a word
    assign is_word = op_size[1];
    assign is_half = (op_size == 2'b01);

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    assign misalign = (is_half && op_addr[0]) || (is_word && (op_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Halfword lane only looks at addr[1], so odd halfword addresses are
    // forced to alignment when trapping is disabled.
    assign byte_sh      = {op_addr[1:0], 3'b000};
    assign half_sh      = {op_addr[1], 4'b0000};
    assign byte_shifted = mem_rd >> byte_sh;
    assign byte_val     = byte_shifted[7:0];
    assign half_val     = op_addr[1] ? mem_rd[31:16] : mem_rd[15:0];

    always_comb begin
        load_val = mem_rd;
        if (is_half) begin
            load_val = {{16{half_val[15] & ~op_uns}}, half_val};
        end else if (!is_word) begin
            load_val = {{24{byte_val[7] & ~op_uns}}, byte_val};
        end
    end

    always_comb begin
        lane_mask = 32'h0000_0000;
        lane_data = 32'h0000_0000;
        if (is_half) begin
            lane_mask = 32'h0000_FFFF << half_sh;
            lane_data = {16'h0000, op_wdata[15:0]} << half_sh;
        end else begin
            lane_mask = 32'h0000_00FF << byte_sh;
            lane_data = {24'h000000, op_wdata[7:0]} << byte_sh;
        end
        merged = (mem_rd & ~lane_mask) | lane_data;
    end

    // Next-state and memory port / handshake outputs
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_wd     = 32'h0000_0000;
        mem_addr   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = op_addr[DMEM_AW+1:2];
                if (misalign || !op_we) begin
                    state_nxt = RESP;
                end else if (is_word) begin
                    mem_we    = 1'b1;
                    mem_wd    = op_wdata;
                    state_nxt = RESP;
                end else begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                mem_addr  = op_addr[DMEM_AW+1:2];
                mem_we    = 1'b1;
                mem_wd    = merge_word;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            op_we      <= 1'b0;
            op_size    <= 2'b00;
            op_uns     <= 1'b0;
            op_addr    <= '0;
            op_wdata   <= 32'h0000_0000;
            merge_word <= 32'h0000_0000;
            rdata_q    <= 32'h0000_0000;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_we    <= req_we;
                        op_size  <= req_size;
                        op_uns   <= req_unsigned;
                        op_addr  <= req_addr;
                        op_wdata <= req_wdata;
                    end
                end
                ACCESS: begin
                    merge_word <= merged;
                    err_q      <= misalign;
                    rdata_q    <= (op_we || misalign) ? 32'h0000_0000 : load_val;
                end
                RESP: begin
                    if (resp_ready) begin
                        rdata_q <= 32'h0000_0000;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_lsu
// Description : Self-checking bench for dmem_lsu. A byte-array reference
//               model predicts load data, errors, latency, write counts and
//               memory contents for directed and random transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

    localparam int AW = 9;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;

    logic [31:0] mem [0:(1<<AW)-1];
    logic [7:0]  refm [0:(4<<AW)-1];
    logic        init_done = 1'b0;

    always #5 clock = ~clock;

    dmem_lsu #(.DMEM_AW(AW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    function automatic logic [31:0] seed_word(input int i);
        return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Memory: combinational read, write on the rising edge
    assign mem_rd = mem[mem_addr];
    always @(posedge clock) begin
        if (!init_done) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= seed_word(i);
            init_done <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (mem_we) we_cnt++;
        else if (reset_n && init_done) check("mem_wd_idle", mem_wd, 32'h0);
    end

    function automatic logic [31:0] ref_word(input int byte_addr);
        int b;
        b = byte_addr & ~3;
        return {refm[b+3], refm[b+2], refm[b+1], refm[b]};
    endfunction

    function automatic bit is_trap(input logic [1:0] size, input logic [AW+1:0] addr);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        if (size == 2'b01) return addr[0];
        if (size[1])       return addr[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW+1:0] addr, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd);
        int n, ea, lat, exp_lat, exp_we, w0, wait_n;
        bit trap;
        logic [31:0] exp_rd, v, rd0;
        n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        ea   = int'(addr) & ~(n - 1);
        trap = is_trap(size, addr);
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(refm[ea+i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        exp_rd  = (we || trap) ? 32'h0 : v;
        exp_lat = (we && !trap && n < 4) ? 3 : 2;
        exp_we  = (we && !trap) ? 1 : 0;

        resp_ready   = (hold == 0);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        wait_n = 0;
        while (!req_ready && wait_n < 20) begin
            @(negedge clock);
            wait_n++;
        end
        check("req_ready_accept", req_ready, 1);
        w0 = we_cnt;
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge clock);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", resp_err, trap);
        rd = resp_rdata;
        if (hold > 0) begin
            rd0 = resp_rdata;
            repeat (hold) begin
                @(negedge clock);
                check("hold_valid", resp_valid, 1);
                check("hold_rdata", resp_rdata, rd0);
                check("hold_req_ready", req_ready, 0);
            end
            resp_ready = 1'b1;
        end
        @(negedge clock);
        check("resp_valid_drop", resp_valid, 0);
        check("req_ready_after", req_ready, 1);
        check("mem_we_count", we_cnt - w0, exp_we);
        if (we && !trap) begin
            for (int i = 0; i < n; i++) refm[ea+i] = wd[8*i +: 8];
        end
        check("mem_word", mem[ea >> 2], ref_word(ea));
    endtask

    initial begin
        logic [31:0] rd, wsave;
        logic        we_r;
        logic [1:0]  sz_r;
        logic [AW+1:0] ad_r;
        int          hold_r;

        for (int i = 0; i < (1 << AW); i++) begin
            wsave = seed_word(i);
            for (int b = 0; b < 4; b++) refm[4*i+b] = wsave[8*b +: 8];
        end
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wd", mem_wd, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_req_ready", req_ready, 1);

        // sw / lw
        xact(1'b1, 2'b10, 1'b0, 11'h010, 32'hDEADBEEF, 0, rd);
        xact(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 0, rd);
        check("lw_deadbeef", rd, 32'hDEADBEEF);
        // sb merge and signed/unsigned byte loads
        xact(1'b1, 2'b10, 1'b0, 11'h010, 32'h11223344, 0, rd);
        xact(1'b1, 2'b00, 1'b0, 11'h013, 32'h000000A5, 0, rd);
        check("sb_word", mem[4], 32'hA5223344);
        xact(1'b0, 2'b00, 1'b0, 11'h013, 32'h0, 0, rd);
        check("lb", rd, 32'hFFFFFFA5);
        xact(1'b0, 2'b00, 1'b1, 11'h013, 32'h0, 0, rd);
        check("lbu", rd, 32'h000000A5);
        // sh upper half
        xact(1'b1, 2'b01, 1'b0, 11'h012, 32'h00008001, 0, rd);
        xact(1'b0, 2'b01, 1'b0, 11'h012, 32'h0, 0, rd);
        check("lh", rd, 32'hFFFF8001);
        xact(1'b0, 2'b01, 1'b1, 11'h012, 32'h0, 0, rd);
        check("lhu", rd, 32'h00008001);
        xact(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 0, rd);
        check("lw_after_sh", rd, 32'h80013344);
        // back-pressure, then back-to-back request
        xact(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 5, rd);
        xact(1'b0, 2'b00, 1'b1, 11'h010, 32'h0, 0, rd);
        check("lbu_b2b", rd, 32'h00000044);
        // misaligned word load
        xact(1'b0, 2'b10, 1'b0, 11'h011, 32'h0, 0, rd);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        check("lw_mis", rd, 32'h0);
`else
        check("lw_mis", rd, 32'h80013344);
`endif

        // reset during WRITE of a byte store
        wsave = mem[4];
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 11'h013; req_wdata = 32'h0000005C;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        check("write_phase_we", mem_we, 1);
        #2 reset_n = 1'b0;
        #1 check("rst_we_drop", mem_we, 0);
        check("rst_wd_drop", mem_wd, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check("rst_word_kept", mem[4], wsave);
        check("rst_word_ref", mem[4], ref_word(16));
        check("rst_no_resp", resp_valid, 0);
        check("rst_release_ready", req_ready, 1);
        @(negedge clock);
        check("rst_release_ready2", req_ready, 1);

        // random traffic
        for (int k = 0; k < 150; k++) begin
            we_r   = 1'($urandom_range(0, 1));
            sz_r   = 2'($urandom_range(0, 3));
            ad_r   = (k % 8 == 7) ? (AW+2)'($urandom) : (AW+2)'($urandom_range(0, 63));
            hold_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            xact(we_r, sz_r, 1'($urandom_range(0, 1)), ad_r, $urandom, hold_r, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DMEM_AW, default 9: word-address width of the data memory port.
REQ-002 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: the CPU request is valid.
REQ-005 SHALL have port req_ready, output, 1: the unit accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2: 00 byte, 01 halfword, 10 word; 11 is reserved and treated as word.
REQ-008 SHALL have port req_unsigned, input, 1: zero-extend loads when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr, input, DMEM_AW+2: the byte address.
REQ-010 SHALL have port req_wdata, input, 32: store data, right-justified.
REQ-011 SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_rdata (output, 32) and resp_err (output, 1): the response channel.
REQ-012 SHALL have ports mem_we (output, 1), mem_addr (output, DMEM_AW), mem_wd (output, 32) and mem_rd (input, 32): the data memory port.
- The memory writes on the clock edge when mem_we is high.
- mem_rd is a combinational read of mem_addr.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, WRITE and RESP.
REQ-014 SHALL assert req_ready only in IDLE; a request is accepted on req_valid&&req_ready, and the request fields are registered.
REQ-015 SHALL, in ACCESS, drive mem_addr = registered addr[DMEM_AW+1:2].
- Load: sample mem_rd, then go to RESP.
- Word store: assert mem_we with mem_wd = wdata, then go to RESP.
- Sub-word store: sample mem_rd, then go to WRITE.
REQ-016 SHALL, in WRITE, assert mem_we for exactly one cycle with the merged word (old word, target lanes replaced), then go to RESP.
REQ-017 SHALL use little-endian byte lanes.
- Byte offset k maps to bits 8k+7:8k.
- Halfword offset 0 maps to bits 15:0; offset 2 maps to bits 31:16.
REQ-018 SHALL return on loads the selected lane, sign- or zero-extended per req_unsigned; stores SHALL return resp_rdata = 0.
REQ-019 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready is high; on handshake it returns to IDLE.
- A new request can be accepted in the following cycle.
REQ-020 SHALL have this latency from the accept edge: loads and word stores give resp_valid 2 cycles later; sub-word stores give resp_valid 3 cycles later.
REQ-021 SHALL assert mem_we in no state other than ACCESS (word store) and WRITE; mem_wd SHALL be 0 whenever mem_we is low.
REQ-022 SHALL, when resp_ready is already high on entry to RESP, complete in that cycle (single-cycle RESP).

Reset
REQ-023 SHALL, while reset_n is low, asynchronously force the following:
- State IDLE; req_ready 1 after release.
- resp_valid 0, resp_rdata 0, resp_err 0.
- mem_we 0, mem_addr 0, mem_wd 0.
- All registered request fields 0.
REQ-024 SHALL abort any in-flight operation on reset, including a pending WRITE; no memory write occurs and no response is produced.

Configuration
REQ-025 SHALL provide macro DMEM_LSU_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0]=1 or a word with addr[1:0]!=0 goes from ACCESS to RESP with resp_err=1 and resp_rdata=0; mem_we is never asserted.
- Undefined: misaligned low address bits are ignored (forced alignment) and resp_err is tied 0.

Verification
REQ-026 SHALL cover: sw addr 0x010 data 0xDEADBEEF, then lw 0x010 -> resp_rdata 0xDEADBEEF, resp_valid at accept+2, resp_err 0.
REQ-027 SHALL cover: word 0x010 = 0x11223344, sb 0x013 data 0xA5 -> memory word 0xA5223344, resp at accept+3; then lb 0x013 -> 0xFFFFFFA5 and lbu 0x013 -> 0x000000A5.
REQ-028 SHALL cover: sh 0x012 data 0x8001 -> lh 0x012 returns 0xFFFF8001, lhu returns 0x00008001, lw 0x010 returns 0x8001xxxx (low half unchanged).
REQ-029 SHALL cover: resp_ready held low 5 cycles after lw -> resp_valid/resp_rdata stable, req_ready 0 throughout; the next request is accepted one cycle after the handshake.
REQ-030 SHALL cover: lw 0x011 -> with the macro, resp_err 1, rdata 0, no mem_we; without it, the word at 0x010 is returned and resp_err 0.
REQ-031 SHALL cover: reset_n pulsed low during WRITE of sb -> mem_we drops immediately, the memory word is unchanged, and req_ready is 1 in the first cycle after release.
